// File: rtl/key_port_arbiter_if.sv
// Bundle between PE requesters, the arbiter and a two-slot key store.
// Latency: none (wires only).
// Backpressure: requesters hold their request until gnt; the key store cannot stall.
interface key_port_arbiter_if #(
    parameter int key_width   = 32,
    parameter int index_width = 8,
    parameter int PE          = 4
);
    logic [PE-1:0]             req;
    logic [PE-1:0]             we;
    logic [PE*index_width-1:0] addr;
    logic [PE*key_width-1:0]   wdata;
    logic [PE-1:0]             gnt;
    logic [PE-1:0]             rvalid;
    logic [PE*key_width-1:0]   rdata;
    logic [2*index_width-1:0]  kr_w_addr;
    logic [2*index_width-1:0]  kr_r_addr;
    logic [2*key_width-1:0]    kr_key_in_write;
    logic [1:0]                kr_w_en;
    logic [1:0]                kr_r_en;
    logic [2*key_width-1:0]    kr_key_out_read;
    logic [15:0]               stall_cnt;

    // Arbiter side.
    modport slave (
        input  req, we, addr, wdata, kr_key_out_read,
        output gnt, rvalid, rdata, kr_w_addr, kr_r_addr, kr_key_in_write,
               kr_w_en, kr_r_en, stall_cnt
    );

    // Requester / key-store side.
    modport master (
        output req, we, addr, wdata, kr_key_out_read,
        input  gnt, rvalid, rdata, kr_w_addr, kr_r_addr, kr_key_in_write,
               kr_w_en, kr_r_en, stall_cnt
    );
endinterface

// File: rtl/key_port_arbiter.sv
// Round-robin arbiter mapping up to two of PE requesters onto a dual-slot key store.
// Latency: grant and key-store command same cycle; read data returns one cycle after grant.
// Backpressure: losing requesters keep req high and are counted in stall_cnt; no read stall.
module key_port_arbiter #(
    parameter int key_width   = 32,
    parameter int index_width = 8,
    parameter int PE          = 4
) (
    input  logic clk,
    input  logic reset,
    key_port_arbiter_if.slave bus
);
    localparam int PTR_W = (PE > 1) ? $clog2(PE) : 1;

    logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [PE-1:0]          rvalid_q, rvalid_d;
    logic [PE-1:0]          slot_q, slot_d;        // key-store slot owning each pending read
    logic [15:0]            stall_cnt_q, stall_cnt_d;

    logic [PE-1:0]          gnt;
    logic [1:0]             w_en, r_en;
    logic [index_width-1:0] addr_a   [PE];
    logic [key_width-1:0]   wdata_a  [PE];
    logic [key_width-1:0]   rdata_a  [PE];
    logic [key_width-1:0]   kout_a   [2];
    logic [index_width-1:0] w_addr_a [2];
    logic [index_width-1:0] r_addr_a [2];
    logic [key_width-1:0]   w_data_a [2];

    logic [PTR_W-1:0]       idx;
    logic [PTR_W-1:0]       last_idx;
    logic [1:0]             n_sel;
    logic                   slot;
    logic                   conflict;
    logic [index_width-1:0] sel_addr;
    logic                   sel_we;

    for (genvar p = 0; p < PE; p++) begin : g_pe
        assign addr_a[p]  = bus.addr[p*index_width +: index_width];
        assign wdata_a[p] = bus.wdata[p*key_width +: key_width];
        assign bus.rdata[p*key_width +: key_width] = rdata_a[p];
    end

    assign kout_a[0]           = bus.kr_key_out_read[0 +: key_width];
    assign kout_a[1]           = bus.kr_key_out_read[key_width +: key_width];
    assign bus.kr_w_addr       = {w_addr_a[1], w_addr_a[0]};
    assign bus.kr_r_addr       = {r_addr_a[1], r_addr_a[0]};
    assign bus.kr_key_in_write = {w_data_a[1], w_data_a[0]};
    assign bus.kr_w_en         = w_en;
    assign bus.kr_r_en         = r_en;
    assign bus.gnt             = gnt;
    assign bus.rvalid          = rvalid_q;
    assign bus.stall_cnt       = stall_cnt_q;

    // Scan from rr_ptr, pick up to two non-conflicting requesters and drive their slots.
    always_comb begin
        gnt      = '0;
        w_en     = '0;
        r_en     = '0;
        slot_d   = '0;
        idx      = '0;
        last_idx = '0;
        n_sel    = '0;
        slot     = 1'b0;
        conflict = 1'b0;
        sel_addr = '0;
        sel_we   = 1'b0;
        for (int s = 0; s < 2; s++) begin
            w_addr_a[s] = '0;
            r_addr_a[s] = '0;
            w_data_a[s] = '0;
        end
        // Grants and key-store commands stay silent while reset is held.
        if (reset) begin
            for (int i = 0; i < PE; i++) begin
                idx      = PTR_W'((int'(rr_ptr_q) + i) % PE);
                slot     = n_sel[0];
                // Same address blocks the second pick unless both are reads.
                conflict = (n_sel == 2'd1) && (addr_a[idx] == sel_addr) &&
                           (bus.we[idx] || sel_we);
                if (bus.req[idx] && (n_sel < 2'd2) && !conflict) begin
                    gnt[idx]    = 1'b1;
                    slot_d[idx] = slot;
                    if (bus.we[idx]) begin
                        w_en[slot]     = 1'b1;
                        w_addr_a[slot] = addr_a[idx];
                        w_data_a[slot] = wdata_a[idx];
                    end else begin
                        r_en[slot]     = 1'b1;
                        r_addr_a[slot] = addr_a[idx];
                    end
                    if (n_sel == 2'd0) begin
                        sel_addr = addr_a[idx];
                        sel_we   = bus.we[idx];
                    end
                    last_idx = idx;
                    n_sel    = n_sel + 2'd1;
                end
            end
        end
    end

    // Next-state for pointer, read tracking and stall counter.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        rvalid_d    = gnt & ~bus.we;
        stall_cnt_d = stall_cnt_q;
        if (|gnt) begin
            rr_ptr_d = (last_idx == PTR_W'(PE - 1)) ? '0 : last_idx + 1'b1;
        end
        if ((|(bus.req & ~gnt)) && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Steer returning key-store data to the requester that owns the slot.
    always_comb begin
        for (int p = 0; p < PE; p++) begin
            rdata_a[p] = '0;
            if (rvalid_q[p]) begin
                rdata_a[p] = kout_a[slot_q[p]];
            end
        end
    end

    // State registers; reset drops any read in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q    <= '0;
            rvalid_q    <= '0;
            slot_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            rvalid_q    <= rvalid_d;
            slot_q      <= slot_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
endmodule

// File: tb/tb_key_port_arbiter.sv
// Scoreboarded bench for key_port_arbiter with a behavioural dual-slot key store.
// Latency: key store returns read data one clock after kr_r_en.
// Backpressure: stimulus re-drives requests until the expected grant cycle.
module tb_key_port_arbiter;
    localparam int KW = 32;
    localparam int IW = 8;
    localparam int NP = 4;

    typedef struct {
        int            due;
        int            pe;
        logic [KW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    exp_t sb[$];

    logic [KW-1:0]   ref_mem [256];
    logic [KW-1:0]   ks_mem  [256];
    logic            ks_wr   [256] = '{default: 1'b0};
    logic [2*KW-1:0] ks_rd = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    key_port_arbiter_if #(.key_width(KW), .index_width(IW), .PE(NP)) bus ();

    key_port_arbiter #(.key_width(KW), .index_width(IW), .PE(NP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [KW-1:0] init_pat(input logic [IW-1:0] a);
        return {16'hA5C3, a, ~a};
    endfunction

    // Behavioural key store: registered read, unwritten locations hold init_pat.
    assign bus.kr_key_out_read = ks_rd;
    always @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (bus.kr_r_en[s]) begin
                ks_rd[s*KW +: KW] <= ks_wr[bus.kr_r_addr[s*IW +: IW]] ?
                                     ks_mem[bus.kr_r_addr[s*IW +: IW]] :
                                     init_pat(bus.kr_r_addr[s*IW +: IW]);
            end
            if (bus.kr_w_en[s]) begin
                ks_mem[bus.kr_w_addr[s*IW +: IW]] <= bus.kr_key_in_write[s*KW +: KW];
                ks_wr[bus.kr_w_addr[s*IW +: IW]]  <= 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic w, input logic [IW-1:0] a, input logic [KW-1:0] d);
        bus.req[p]            = 1'b1;
        bus.we[p]             = w;
        bus.addr[p*IW +: IW]  = a;
        bus.wdata[p*KW +: KW] = d;
    endtask

    task automatic clr_req(input int p);
        bus.req[p] = 1'b0;
    endtask

    task automatic exp_read(input int p, input logic [IW-1:0] a);
        sb.push_back('{cyc + 1, p, ref_mem[a]});
    endtask

    task automatic exp_write(input logic [IW-1:0] a, input logic [KW-1:0] d);
        ref_mem[a] = d;
    endtask

    // Check grant and any read returns due this cycle.
    task automatic step(input string tag, input logic [NP-1:0] eg);
        logic [NP-1:0] em;
        logic [KW-1:0] ed [NP];
        @(negedge clk);
        chk({tag, ".gnt"}, 64'(bus.gnt), 64'(eg));
        em = '0;
        for (int p = 0; p < NP; p++) ed[p] = '0;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due <= cyc) begin
                em[sb[i].pe] = 1'b1;
                ed[sb[i].pe] = sb[i].data;
                sb.delete(i);
            end
        end
        chk({tag, ".rvalid"}, 64'(bus.rvalid), 64'(em));
        for (int p = 0; p < NP; p++) begin
            chk($sformatf("%s.rdata%0d", tag, p), 64'(bus.rdata[p*KW +: KW]), 64'(ed[p]));
        end
    endtask

    task automatic do_reset();
        bus.req = '0;
        #1 reset = 1'b0;
        #1;
        chk("rst.stall", 64'(bus.stall_cnt), 64'd0);
        chk("rst.rvalid", 64'(bus.rvalid), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    initial begin
        for (int a = 0; a < 256; a++) ref_mem[a] = init_pat(IW'(a));
        reset     = 1'b0;
        bus.req   = '1;
        bus.we    = '0;
        bus.addr  = {8'h03, 8'h02, 8'h01, 8'h00};
        bus.wdata = '1;
        #2;
        chk("rst.gnt",    64'(bus.gnt),       64'd0);
        chk("rst.r_en",   64'(bus.kr_r_en),   64'd0);
        chk("rst.w_en",   64'(bus.kr_w_en),   64'd0);
        chk("rst.r_addr", 64'(bus.kr_r_addr), 64'd0);
        chk("rst.rvalid", 64'(bus.rvalid),    64'd0);
        chk("rst.stall",  64'(bus.stall_cnt), 64'd0);
        bus.req = '0;
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Write then read through the same address.
        set_req(0, 1'b1, 8'h05, 32'hDEADBEEF);
        exp_write(8'h05, 32'hDEADBEEF);
        step("wr", 4'b0001);
        chk("wr.w_en",   64'(bus.kr_w_en), 64'd1);
        chk("wr.r_en",   64'(bus.kr_r_en), 64'd0);
        chk("wr.w_addr", 64'(bus.kr_w_addr[7:0]), 64'h05);
        chk("wr.w_data", 64'(bus.kr_key_in_write[31:0]), 64'hDEADBEEF);
        tick();
        clr_req(0);
        set_req(1, 1'b0, 8'h05, '0);
        exp_read(1, 8'h05);
        step("rd", 4'b0010);
        chk("rd.r_en",   64'(bus.kr_r_en), 64'd1);
        chk("rd.r_addr", 64'(bus.kr_r_addr[7:0]), 64'h05);
        tick();
        clr_req(1);
        step("rd.ret", 4'b0000);
        chk("rd.stall", 64'(bus.stall_cnt), 64'd0);
        tick();

        // Four continuous readers from reset: pairs alternate, two stall each cycle.
        do_reset();
        for (int p = 0; p < NP; p++) set_req(p, 1'b0, IW'(8'h40 + p), '0);
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) begin
                exp_read(0, 8'h40);
                exp_read(1, 8'h41);
            end else begin
                exp_read(2, 8'h42);
                exp_read(3, 8'h43);
            end
            step($sformatf("rr%0d", k), (k % 2 == 0) ? 4'b0011 : 4'b1100);
            chk($sformatf("rr%0d.stall", k), 64'(bus.stall_cnt), 64'(k));
            tick();
        end
        bus.req = '0;
        step("rr.drain", 4'b0000);
        tick();

        // Write-write conflict on one address.
        do_reset();
        set_req(0, 1'b1, 8'h10, 32'h11111111);
        set_req(1, 1'b1, 8'h10, 32'h22222222);
        exp_write(8'h10, 32'h11111111);
        step("ww1", 4'b0001);
        chk("ww1.w_en", 64'(bus.kr_w_en), 64'd1);
        tick();
        clr_req(0);
        exp_write(8'h10, 32'h22222222);
        step("ww2", 4'b0010);
        chk("ww2.stall", 64'(bus.stall_cnt), 64'd1);
        tick();
        clr_req(1);
        set_req(3, 1'b0, 8'h10, '0);
        exp_read(3, 8'h10);
        step("ww.rd", 4'b1000);
        tick();
        clr_req(3);
        step("ww.drain", 4'b0000);
        tick();

        // Read/write conflict starting from rr_ptr=2.
        set_req(1, 1'b0, 8'h21, '0);
        exp_read(1, 8'h21);
        step("rw.prep", 4'b0010);
        tick();
        clr_req(1);
        set_req(2, 1'b1, 8'h20, 32'hCAFEF00D);
        set_req(3, 1'b0, 8'h20, '0);
        exp_write(8'h20, 32'hCAFEF00D);
        step("rw1", 4'b0100);
        tick();
        clr_req(2);
        exp_read(3, 8'h20);
        step("rw2", 4'b1000);
        tick();
        clr_req(3);
        step("rw.drain", 4'b0000);
        tick();

        // Read and write to distinct addresses share a cycle.
        set_req(0, 1'b1, 8'h50, 32'h50505050);
        set_req(1, 1'b0, 8'h20, '0);
        exp_read(1, 8'h20);
        exp_write(8'h50, 32'h50505050);
        step("mix", 4'b0011);
        chk("mix.w_en",   64'(bus.kr_w_en), 64'd1);
        chk("mix.r_en",   64'(bus.kr_r_en), 64'd2);
        chk("mix.r_addr", 64'(bus.kr_r_addr), 64'h2000);
        chk("mix.w_addr", 64'(bus.kr_w_addr), 64'h0050);
        tick();
        bus.req = '0;
        step("mix.drain", 4'b0000);
        tick();

        // Two reads to one address, scanned across the wrap.
        set_req(0, 1'b0, 8'h33, '0);
        set_req(1, 1'b0, 8'h33, '0);
        exp_read(0, 8'h33);
        exp_read(1, 8'h33);
        step("rr33", 4'b0011);
        chk("rr33.r_en",   64'(bus.kr_r_en), 64'd3);
        chk("rr33.r_addr", 64'(bus.kr_r_addr), 64'h3333);
        tick();
        bus.req = '0;
        step("rr33.ret", 4'b0000);
        tick();

        // Reset in the cycle after a read grant discards the return.
        set_req(2, 1'b0, 8'h60, '0);
        step("mid", 4'b0100);
        tick();
        clr_req(2);
        #1 reset = 1'b0;
        #1;
        chk("mid.rvalid", 64'(bus.rvalid), 64'd0);
        chk("mid.rdata",  64'(bus.rdata),  64'd0);
        chk("mid.stall",  64'(bus.stall_cnt), 64'd0);
        for (int p = 0; p < NP; p++) set_req(p, 1'b0, IW'(8'h70 + p), '0);
        #1;
        chk("mid.gnt",  64'(bus.gnt),     64'd0);
        chk("mid.r_en", 64'(bus.kr_r_en), 64'd0);
        bus.req = '0;
        @(negedge clk);
        reset = 1'b1;
        step("mid.rel", 4'b0000);
        tick();
        for (int p = 0; p < NP; p++) set_req(p, 1'b0, IW'(8'h70 + p), '0);
        exp_read(0, 8'h70);
        exp_read(1, 8'h71);
        step("mid.first", 4'b0011);
        tick();
        bus.req = '0;
        step("mid.drain", 4'b0000);
        chk("sb.empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
